// File: rtl/i8088_bus_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i8088_bus_pkg                                                 |
// | Purpose  : Shared types and constants for the 8088 bus-cycle initiator.  |
// |            Bus state encoding, inactive strobe level and the data value  |
// |            returned when a cycle times out on READY.                     |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package i8088_bus_pkg;

  // IDLE is the all-zero code so each active bus state (T1..T4, TW) owns
  // exactly one bit of the 5-bit state register.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00000,
    S_T1   = 5'b00001,
    S_T2   = 5'b00010,
    S_T3   = 5'b00100,
    S_TW   = 5'b01000,
    S_T4   = 5'b10000
  } state_t;

  // RD, WR and DEN are active low; this is their parked level.
  localparam logic       c_strobe_off    = 1'b1;

  // Read data reported for a cycle aborted by the wait-state timeout.
  localparam logic [7:0] c_timeout_rdata = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/i8088_bus_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i8088_bus_master_if                                           |
// | Purpose  : Request/response handshake plus 8088 local-bus control pins.  |
// |            master : the bus-cycle initiator                              |
// |            slave  : sequencer / peripheral side                          |
// | Ports    : req_valid/ready/write/io/addr/wdata, rsp_valid/rdata/err,     |
// |            READY, ALE, RD, WR, IOM, DTR, DEN, A_HI                        |
// |            (the multiplexed AD bus stays a plain inout net on the top)   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface i8088_bus_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;

  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  logic        READY;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic        DTR;
  logic        DEN;
  logic [11:0] A_HI;

  modport master (
    input  req_valid, req_write, req_io, req_addr, req_wdata, READY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ALE, RD, WR, IOM, DTR, DEN, A_HI
  );

  modport slave (
    output req_valid, req_write, req_io, req_addr, req_wdata, READY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ALE, RD, WR, IOM, DTR, DEN, A_HI
  );

endinterface
`default_nettype wire

// File: rtl/i8088_bus_master_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i8088_wait_timer                                              |
// | Purpose  : Counts consecutive Tw states and flags when the current Tw    |
// |            is the MAX_WAIT-th one. MAX_WAIT = 0 never expires.           |
// | Ports    : clk, rst (async, active high)                                 |
// |            i_clr     - restart the count at 0                            |
// |            i_inc     - count one Tw (saturating)                         |
// |            o_expired - current Tw is the last one allowed                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module i8088_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int c_cw  = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  // The count is 0 during the first Tw, so the last allowed Tw sees MAX_WAIT-1.
  localparam int c_lim = (MAX_WAIT < 1) ? 0 : MAX_WAIT - 1;

  logic [c_cw-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {c_cw{1'b1}})) begin
      r_count <= r_count + c_cw'(1);
    end
  end

  assign o_expired = (MAX_WAIT != 0) && (r_count >= c_cw'(c_lim));

endmodule
`default_nettype wire

// File: rtl/i8088_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i8088_bus_master                                              |
// | Purpose  : Turns one request/response transaction into an 8088 T1..T4   |
// |            bus cycle, inserting Tw states while READY is low and         |
// |            aborting with an error after MAX_WAIT of them.                |
// | Ports    : CLK, RESET (async, active high)                               |
// |            bus - handshake and bus control pins (master modport)         |
// |            AD  - multiplexed address[7:0] / data bus (tri-state)         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module i8088_bus_master
  import i8088_bus_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                      CLK,
  input  logic                      RESET,
  i8088_bus_master_if.master        bus,
  inout  wire  [7:0]                AD
);

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic        r_io;
  logic [19:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        r_err;

  logic        w_tw_clr;
  logic        w_tw_inc;
  logic        w_expired;
  logic        w_timeout;
  logic        w_accept;
  logic        w_in_cycle;
  logic        w_strobe;
  logic        w_ad_oe;
  logic [7:0]  w_ad_out;

  i8088_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (CLK),
    .rst       (RESET),
    .i_clr     (w_tw_clr),
    .i_inc     (w_tw_inc),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and timer controls
  always_comb begin
    w_next    = r_state;
    w_tw_clr  = 1'b0;
    w_tw_inc  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_valid) w_next = S_T1;
      S_T1:   w_next = S_T2;
      S_T2:   w_next = S_T3;
      S_T3: begin
        w_tw_clr = 1'b1;
        w_next   = bus.READY ? S_T4 : S_TW;
      end
      S_TW: begin
        w_tw_inc = 1'b1;
        if (bus.READY) begin
          w_next = S_T4;
        end else if (w_expired) begin
          w_next    = S_T4;
          w_timeout = 1'b1;
        end
      end
      S_T4:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  // Request latch and response capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_write <= 1'b0;
      r_io    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_io    <= bus.req_io;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_err   <= 1'b0;
      end
      // Data is taken from the pins on the edge that ends T3/Tw with READY.
      if (((r_state == S_T3) || (r_state == S_TW)) && bus.READY) begin
        r_rdata <= AD;
      end else if (w_timeout) begin
        r_rdata <= c_timeout_rdata;
        r_err   <= 1'b1;
      end
    end
  end

  // Pin decode: everything below depends only on registered state.
  assign w_in_cycle = (r_state != S_IDLE);
  assign w_strobe   = (r_state == S_T2) || (r_state == S_T3) || (r_state == S_TW);

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_T4);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  assign bus.ALE  = (r_state == S_T1);
  assign bus.RD   = (w_strobe && !r_write) ? 1'b0 : c_strobe_off;
  assign bus.WR   = (w_strobe &&  r_write) ? 1'b0 : c_strobe_off;
  assign bus.DEN  = w_strobe ? 1'b0 : c_strobe_off;
  assign bus.IOM  = w_in_cycle && r_io;
  assign bus.DTR  = w_in_cycle && r_write;
  assign bus.A_HI = w_in_cycle ? r_addr[19:8] : 12'h000;

  // Address in T1; write data from T2 through T4 so it holds past WR rising.
  assign w_ad_oe  = (r_state == S_T1) || (r_write && (w_strobe || (r_state == S_T4)));
  assign w_ad_out = (r_state == S_T1) ? r_addr[7:0] : r_wdata;
  assign AD       = w_ad_oe ? w_ad_out : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_i8088_bus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i8088_bus_master                                           |
// | Purpose  : Directed bench for i8088_bus_master (MAX_WAIT = 4). Stimulus  |
// |            pushes expected responses into a queue; a monitor pops and    |
// |            compares on every rsp_valid. Pin checks are made inline.      |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_i8088_bus_master;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  wire  [7:0] AD;
  logic       pen   = 1'b0;   // peripheral answers reads
  logic [7:0] pdata = 8'h00;

  i8088_bus_master_if bus ();

  // Peripheral drives AD only while RD is asserted.
  assign AD = (pen && !bus.RD) ? pdata : 8'hzz;

  i8088_bus_master #(
    .MAX_WAIT (4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .AD    (AD)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         id;
    int         cyc;
    logic [7:0] rdata;
    logic       err;
    logic       is_read;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   total = 0;
  int   bad   = 0;
  int   nid   = 0;
  int   acc;
  int   prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [7:0] d, input logic e, input logic rd);
    exp_t x;
    x.id = nid; x.cyc = c; x.rdata = d; x.err = e; x.is_read = rd;
    nid++;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic io, input logic [19:0] a, input logic [7:0] d);
    bus.req_write = w;
    bus.req_io    = io;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 1);
    chk({tag, "_rspv"},  bus.rsp_valid, 0);
    chk({tag, "_ale"},   bus.ALE, 0);
    chk({tag, "_rd"},    bus.RD, 1);
    chk({tag, "_wr"},    bus.WR, 1);
    chk({tag, "_den"},   bus.DEN, 1);
    chk({tag, "_iom"},   bus.IOM, 0);
    chk({tag, "_dtr"},   bus.DTR, 0);
    chk({tag, "_ahi"},   bus.A_HI, 0);
  endtask

  // Scoreboard monitor
  always @(posedge CLK) begin
    #2;
    if (bus.rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want none at cyc %0d", cyc);
      end else begin
        m_e = q.pop_front();
        chk($sformatf("rsp%0d_cycle", m_e.id), cyc, m_e.cyc);
        chk($sformatf("rsp%0d_err", m_e.id), bus.rsp_err, m_e.err);
        if (m_e.is_read) chk($sformatf("rsp%0d_rdata", m_e.id), bus.rsp_rdata, m_e.rdata);
      end
    end
  end

  logic [19:0] bb_addr [3] = '{20'h0A0B0, 20'h000FF, 20'hFFFFF};
  logic [7:0]  bb_data [3] = '{8'h11, 8'h22, 8'h33};
  logic        bb_wr   [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_io    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.READY     = 1'b1;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk_idle("reset");
    chk("reset_rdata", bus.rsp_rdata, 0);
    chk("reset_err", bus.rsp_err, 0);
    RESET = 1'b0;
    step();

    // Memory read 0x12345, zero wait, data A5
    pen = 1'b1; pdata = 8'hA5; bus.READY = 1'b1;
    drive(1'b0, 1'b0, 20'h12345, 8'h00);
    step(); acc = cyc; bus.req_valid = 1'b0;
    push(acc + 3, 8'hA5, 1'b0, 1'b1);
    chk("rd_t1_ale", bus.ALE, 1);
    chk("rd_t1_ad", AD, 8'h45);
    chk("rd_t1_ahi", bus.A_HI, 12'h123);
    chk("rd_t1_iom", bus.IOM, 0);
    chk("rd_t1_dtr", bus.DTR, 0);
    chk("rd_t1_rd", bus.RD, 1);
    chk("rd_t1_ready", bus.req_ready, 0);
    step();
    chk("rd_t2_ale", bus.ALE, 0);
    chk("rd_t2_rd", bus.RD, 0);
    chk("rd_t2_wr", bus.WR, 1);
    chk("rd_t2_den", bus.DEN, 0);
    step();
    chk("rd_t3_rd", bus.RD, 0);
    step();
    chk("rd_t4_rd", bus.RD, 1);
    chk("rd_t4_den", bus.DEN, 1);
    chk("rd_t4_ahi", bus.A_HI, 12'h123);
    step();
    chk_idle("rd_end");

    // I/O write 3C to 0x00080
    pen = 1'b0;
    drive(1'b1, 1'b1, 20'h00080, 8'h3C);
    step(); acc = cyc; bus.req_valid = 1'b0;
    push(acc + 3, 8'h00, 1'b0, 1'b0);
    chk("wr_t1_ad", AD, 8'h80);
    chk("wr_t1_iom", bus.IOM, 1);
    chk("wr_t1_dtr", bus.DTR, 1);
    chk("wr_t1_ahi", bus.A_HI, 12'h000);
    step();
    chk("wr_t2_ad", AD, 8'h3C);
    chk("wr_t2_wr", bus.WR, 0);
    chk("wr_t2_rd", bus.RD, 1);
    step();
    chk("wr_t3_ad", AD, 8'h3C);
    chk("wr_t3_wr", bus.WR, 0);
    step();
    chk("wr_t4_ad", AD, 8'h3C);
    chk("wr_t4_wr", bus.WR, 1);
    chk("wr_t4_iom", bus.IOM, 1);
    chk("wr_t4_dtr", bus.DTR, 1);
    step();
    chk_idle("wr_end");

    // Memory read with three wait states; data only valid on the final edge
    pen = 1'b1; pdata = 8'h00; bus.READY = 1'b0;
    drive(1'b0, 1'b0, 20'hF0F0F, 8'h00);
    step(); acc = cyc; bus.req_valid = 1'b0;
    push(acc + 6, 8'h5A, 1'b0, 1'b1);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ws_tw%0d_rd", i), bus.RD, 0);
      chk($sformatf("ws_tw%0d_rspv", i), bus.rsp_valid, 0);
    end
    bus.READY = 1'b1; pdata = 8'h5A;
    step();
    chk("ws_t4_rd", bus.RD, 1);
    step();
    chk_idle("ws_end");

    // Timeout: READY stuck low, MAX_WAIT = 4
    pen = 1'b1; pdata = 8'h77; bus.READY = 1'b0;
    drive(1'b0, 1'b1, 20'h0BEEF, 8'h00);
    step(); acc = cyc; bus.req_valid = 1'b0;
    push(acc + 7, 8'hFF, 1'b1, 1'b1);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("to_tw%0d_rd", i), bus.RD, 0);
    end
    step();
    chk("to_t4_rd", bus.RD, 1);
    chk("to_t4_den", bus.DEN, 1);
    step();
    chk_idle("to_end");
    bus.READY = 1'b1;

    // Reset pulsed during Tw of a write
    pen = 1'b0; bus.READY = 1'b0;
    drive(1'b1, 1'b0, 20'h54321, 8'hE7);
    step(); bus.req_valid = 1'b0;
    step(); step(); step();
    chk("rst_tw_wr", bus.WR, 0);
    #2;
    RESET = 1'b1;
    #1;
    chk_idle("rst_async");
    step();
    RESET = 1'b0;
    bus.READY = 1'b1;
    step();
    pen = 1'b1; pdata = 8'hC3;
    drive(1'b0, 1'b0, 20'hABCDE, 8'h00);
    step(); acc = cyc; bus.req_valid = 1'b0;
    push(acc + 3, 8'hC3, 1'b0, 1'b1);
    chk("rst_next_ad", AD, 8'hDE);
    repeat (4) step();
    chk_idle("rst_next_end");

    // Back-to-back with req_valid held high
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      pen   = !bb_wr[k];
      pdata = bb_data[k];
      drive(bb_wr[k], bb_wr[k], bb_addr[k], bb_data[k]);
      step(); acc = cyc;
      if (k == 2) bus.req_valid = 1'b0;
      push(acc + 3, bb_data[k], 1'b0, !bb_wr[k]);
      chk($sformatf("bb%0d_ale", k), bus.ALE, 1);
      chk($sformatf("bb%0d_t1_ready", k), bus.req_ready, 0);
      if (k > 0) chk($sformatf("bb%0d_spacing", k), acc - prev, 5);
      prev = acc;
      for (int j = 0; j < 3; j++) begin
        step();
        chk($sformatf("bb%0d_ale_low%0d", k, j), bus.ALE, 0);
        chk($sformatf("bb%0d_ready_low%0d", k, j), bus.req_ready, 0);
      end
      step();
      chk($sformatf("bb%0d_idle_ready", k), bus.req_ready, 1);
    end

    repeat (5) step();
    chk("sb_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
